// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam logic [3:0] AN_OFF     = 4'hF;
   localparam int         NUM_DIGITS = 4;
   localparam int         IDX_W      = $clog2(NUM_DIGITS);

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } seg_state_t;

endpackage

// File: rtl/seg_prescaler.sv
// Slot counter for the scan driver; runs one cycle ahead of the registered display outputs.
// Free-running after reset, no backpressure: flags slot start, slot end and the dead-time window.
module seg_prescaler #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic clknew,
   input  logic rst,
   output logic slot_start,
   output logic slot_end,
   output logic in_dead
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clknew) begin
      if (rst) begin
         cnt <= '0;
      end else if (slot_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign slot_start = (cnt == '0);
   assign slot_end   = (cnt == CNT_W'(REFRESH_DIV - 1));

   // Zero dead time must never blank; avoid an always-false unsigned compare.
   generate
      if (DEAD_CYCLES == 0) begin : g_no_dead
         assign in_dead = 1'b0;
      end else begin : g_dead
         assign in_dead = (cnt < CNT_W'(DEAD_CYCLES));
      end
   endgenerate

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scanner: per-frame pattern capture, dead-time blanking, registered outputs.
// No backpressure; optional entry-digit blink is built only when SEG_BLINK_EN is defined.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int DEAD_CYCLES  = 500,
   parameter int BLINK_FRAMES = 62
) (
   input  logic       clknew,
   input  logic       rst,
   input  logic [7:0] d1,
   input  logic [7:0] d2,
   input  logic [7:0] d3,
   input  logic [7:0] d4,
   output logic [7:0] seg,
   output logic [3:0] an,
   output logic       frame
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic                       slot_start;
   logic                       slot_end;
   logic                       in_dead;
   logic [IDX_W-1:0]           idx;
   logic [NUM_DIGITS-1:0][7:0] shadow;
   logic [NUM_DIGITS-1:0][7:0] din;
   logic [NUM_DIGITS-1:0][7:0] src;
   logic                       capture;
   logic                       blink_hide;
   seg_state_t                 slot_state;
   logic [7:0]                 seg_n;
   logic [3:0]                 an_n;
   logic                       frame_n;

   seg_prescaler #(
      .REFRESH_DIV (REFRESH_DIV),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_prescaler (
      .clknew     (clknew),
      .rst        (rst),
      .slot_start (slot_start),
      .slot_end   (slot_end),
      .in_dead    (in_dead)
   );

   assign din     = {d4, d3, d2, d1};
   assign capture = slot_start && (idx == '0);

   // On the capture cycle the new patterns bypass the shadow so slot 0 never shows stale data.
   always_comb begin
      src        = capture ? din : shadow;
      slot_state = in_dead ? BLANK : SHOW;
      seg_n      = SEG_BLANK;
      an_n       = AN_OFF;
      frame_n    = slot_end && (idx == LAST_IDX);
      if (slot_state == SHOW) begin
         an_n  = AN_OFF & ~(4'b0001 << idx);
         seg_n = (blink_hide && (idx == LAST_IDX)) ? SEG_BLANK : src[idx];
      end
   end

   always_ff @(posedge clknew) begin
      if (rst) begin
         idx    <= '0;
         shadow <= {NUM_DIGITS{SEG_BLANK}};
         seg    <= SEG_BLANK;
         an     <= AN_OFF;
         frame  <= 1'b0;
      end else begin
         if (slot_end) begin
            idx <= idx + IDX_W'(1);
         end
         if (capture) begin
            shadow <= din;
         end
         seg   <= seg_n;
         an    <= an_n;
         frame <= frame_n;
      end
   end

`ifdef SEG_BLINK_EN
   localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BC_W-1:0] blink_cnt;
   logic            blink_hidden;

   // Phase flips on the edge that ends a frame, so a whole frame always shares one phase.
   always_ff @(posedge clknew) begin
      if (rst) begin
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
      end else if (frame_n) begin
         if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
         end else begin
            blink_cnt <= blink_cnt + BC_W'(1);
         end
      end
   end

   assign blink_hide = blink_hidden;
`else
   logic unused_blink;

   assign blink_hide   = 1'b0;
   assign unused_blink = (BLINK_FRAMES != 0);
`endif

endmodule
